spi_slave_rx_mode1: RTL and testbench
=====================================

SPI_SLAVE_RX_MODE1 -- requirements
Module: spi_slave_rx_mode1

Interface
REQ-001 The block SHALL have parameter REF_CLK, default 50_000_000, meaning the In_clk frequency in Hz.
REQ-002 The block SHALL have parameter SPI_SCLK, default 50_000, meaning the maximum accepted SCLK frequency in Hz; an elaboration check SHALL enforce REF_CLK >= 8*SPI_SCLK.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth; legal values are 2 and 3.
REQ-004 The block SHALL have port In_clk, input, width 1: the system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port In_rst, input, width 1: reset, asynchronous and active-high.
REQ-006 The block SHALL have port In_spi_cs_n, input, width 1: chip select from the master, active-low, asynchronous to In_clk.
REQ-007 The block SHALL have port In_spi_sclk, input, width 1: SPI clock from the master, asynchronous to In_clk.
REQ-008 The block SHALL have port In_spi_mosi, input, width 1: serial data from the master, asynchronous to In_clk.
REQ-009 The block SHALL have port Out_rx_busy, output, width 1: high while a frame is in progress.
REQ-010 The block SHALL have port Out_rx_valid, output, width 1: a one-cycle pulse that marks a completed byte.
REQ-011 The block SHALL have port Out_rx_data, output, width 8: the last completed byte, held until the next completed byte.

Function
REQ-012 The block SHALL pass In_spi_cs_n, In_spi_sclk and In_spi_mosi through SYNC_STAGES flops each, then detect edges by comparing each synchronized signal with a one-cycle-delayed copy.
REQ-013 The block SHALL operate in SPI mode 1 (CPOL=0, CPHA=1), shifting MSB first: each falling SCLK edge shifts MOSI into the shift register LSB, moving earlier bits toward the MSB; rising edges are ignored.
REQ-014 The block SHALL implement an FSM with states IDLE and RECV.
  - IDLE -> RECV on a synchronized CS_n falling edge; bit counter cleared.
  - RECV -> IDLE on a synchronized CS_n rising edge.
REQ-015 In RECV, each synchronized SCLK falling edge SHALL increment the 3-bit bit counter; at count 7 the counter SHALL wrap to 0.
REQ-016 On that wrap, in the same cycle, the block SHALL load Out_rx_data with the completed byte and assert Out_rx_valid for exactly one In_clk cycle.
REQ-017 Out_rx_valid SHALL rise exactly SYNC_STAGES+1 In_clk cycles after the 8th SCLK falling edge at the pin.
REQ-018 Multiple bytes within one CS_n-low frame SHALL each produce their own Out_rx_valid pulse; the byte boundary is the wrap of the bit counter.
REQ-019 SCLK and MOSI activity while in IDLE SHALL be ignored.
REQ-020 Out_rx_busy SHALL be 1 exactly when the state is RECV.
REQ-021 A CS_n rising edge with a bit count other than 0 SHALL discard the partial byte, SHALL leave Out_rx_data unchanged and SHALL produce no Out_rx_valid pulse.
REQ-022 If a CS_n rising edge and the 8th SCLK falling edge are detected in the same cycle, the byte SHALL complete (Out_rx_valid pulses) and the FSM SHALL then go to IDLE.
REQ-023 If a CS_n falling edge is detected in the same cycle as an SCLK falling edge, that SCLK edge SHALL be ignored.

Reset
REQ-024 In_rst high SHALL asynchronously force:
  - state IDLE;
  - bit counter and shift register to 0;
  - synchronizer flops to CS_n=1, SCLK=0, MOSI=0;
  - Out_rx_busy=0, Out_rx_valid=0, Out_rx_data=8'h00.
REQ-025 A reset asserted mid-frame SHALL abort the frame with no Out_rx_valid pulse.
REQ-026 After reset release, the block SHALL wait for a fresh CS_n falling edge before receiving.

Configuration
REQ-027 With macro SPI_SLAVE_RX_FRAME_ERR_EN defined, the block SHALL add output port Out_rx_err (width 1), which pulses high for one cycle on each REQ-021 abort and is 0 in reset.
REQ-028 Without SPI_SLAVE_RX_FRAME_ERR_EN, port Out_rx_err SHALL not exist and aborts SHALL be silent.

Structure
REQ-029 Shared package spi_pkg SHALL hold:
  - the FSM state typedef (IDLE, RECV);
  - constants SPI_CPOL_MODE1=0, SPI_CPHA_MODE1=1 and SPI_DATA_W=8.
REQ-030 The synchronizer SHALL be a sub-module spi_sync (parameter STAGES, parameter reset value), instantiated once per input.

Verification
REQ-031 The bench SHALL cover: reset, then a master sending 8'h12 in one CS_n frame -> exactly one Out_rx_valid pulse with Out_rx_data=8'h12, and Out_rx_busy high only while CS_n is low.
REQ-032 The bench SHALL cover: a frame sending 8'h55 then 8'hA3 with CS_n held low -> two pulses, with data 8'h55 then 8'hA3.
REQ-033 The bench SHALL cover: CS_n raised after 5 bits of 8'hFF -> no pulse, Out_rx_data keeps its previous value, and Out_rx_err pulses once when SPI_SLAVE_RX_FRAME_ERR_EN is defined.
REQ-034 The bench SHALL cover: SCLK toggling 16 times with CS_n high, then a frame sending 8'h3C -> only 8'h3C is received.
REQ-035 The bench SHALL cover: In_rst asserted after bit 4 of 8'hC7, then a new frame sending 8'h81 -> no pulse for 8'hC7, then a pulse with 8'h81.
REQ-036 The bench SHALL cover: REF_CLK=50_000_000, SPI_SCLK=50_000, byte 8'h12 -> Out_rx_valid rises exactly 3 cycles after the 8th SCLK falling edge (SYNC_STAGES=2).

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI mode-1 receive slave:
//     - spi_state_t    : receive FSM state (IDLE, RECV)
//     - SPI_CPOL_MODE1 : clock polarity of mode 1 (SCLK idles low)
//     - SPI_CPHA_MODE1 : clock phase of mode 1 (sample on the trailing edge)
//     - SPI_DATA_W     : width of one received word
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam logic SPI_CPOL_MODE1 = 1'b0;
  localparam logic SPI_CPHA_MODE1 = 1'b1;
  localparam int   SPI_DATA_W     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
//   Multi-flop synchronizer that brings one asynchronous input into the i_clk
//   domain. The chain resets to RST_VAL, which must be the idle level of the
//   input so that reset release never looks like an edge.
//   Parameters:
//     STAGES  : number of flops in the chain (2 or 3)
//     RST_VAL : value every flop takes in reset
//   Ports:
//     i_clk : sampling clock
//     i_rst : asynchronous active-high reset
//     i_d   : asynchronous input
//     o_q   : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_rx_mode1.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_mode1
//   SPI slave receiver, mode 1 (CPOL=0, CPHA=1), MSB first. CS_n, SCLK and
//   MOSI are oversampled by In_clk; bits are taken on synchronized SCLK
//   falling edges while the FSM is in RECV. Every eighth bit inside a CS_n-low
//   frame completes a byte, which is loaded into Out_rx_data together with a
//   one-cycle Out_rx_valid pulse. A frame that ends mid-byte is discarded.
//
//   Optional feature macro: SPI_SLAVE_RX_FRAME_ERR_EN
//     When defined, adds Out_rx_err, a one-cycle pulse on every discarded
//     partial byte.
//
//   Parameters:
//     REF_CLK     : In_clk frequency in Hz
//     SPI_SCLK    : highest accepted SCLK frequency in Hz (REF_CLK >= 8x this)
//     SYNC_STAGES : synchronizer depth, 2 or 3
//   Ports:
//     In_clk       : system clock, rising edge
//     In_rst       : asynchronous active-high reset
//     In_spi_cs_n  : chip select, active low, asynchronous
//     In_spi_sclk  : SPI clock, asynchronous
//     In_spi_mosi  : serial data in, asynchronous
//     Out_rx_busy  : 1 while a frame is being received (state RECV)
//     Out_rx_valid : one-cycle pulse per completed byte
//     Out_rx_data  : last completed byte, held until the next one
//     Out_rx_err   : (macro only) one-cycle pulse per discarded partial byte
// -----------------------------------------------------------------------------
module spi_slave_rx_mode1
  import spi_pkg::*;
#(
  parameter int REF_CLK     = 50_000_000,
  parameter int SPI_SCLK    = 50_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  In_clk,
  input  logic                  In_rst,
  input  logic                  In_spi_cs_n,
  input  logic                  In_spi_sclk,
  input  logic                  In_spi_mosi,
  output logic                  Out_rx_busy,
  output logic                  Out_rx_valid,
  output logic [SPI_DATA_W-1:0] Out_rx_data
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
  ,
  output logic                  Out_rx_err
`endif
);

  generate
    if (REF_CLK < 8 * SPI_SCLK) begin : g_bad_ratio
      $error("spi_slave_rx_mode1: REF_CLK must be at least 8x SPI_SCLK");
    end
    if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_stages
      $error("spi_slave_rx_mode1: SYNC_STAGES must be 2 or 3");
    end
  endgenerate

  // Synchronizers, each reset to the idle level of its line.
  logic w_cs_s;
  logic w_sclk_s;
  logic w_mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(In_clk), .i_rst(In_rst), .i_d(In_spi_cs_n), .o_q(w_cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL_MODE1)) u_sync_sclk (
    .i_clk(In_clk), .i_rst(In_rst), .i_d(In_spi_sclk), .o_q(w_sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(In_clk), .i_rst(In_rst), .i_d(In_spi_mosi), .o_q(w_mosi_s)
  );

  // One-cycle-delayed copies for edge detection.
  logic r_cs_d;
  logic r_sclk_d;

  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      r_cs_d   <= 1'b1;
      r_sclk_d <= SPI_CPOL_MODE1;
    end else begin
      r_cs_d   <= w_cs_s;
      r_sclk_d <= w_sclk_s;
    end
  end

  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sclk_fall;

  assign w_cs_fall   =  r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d &  w_cs_s;
  assign w_sclk_fall =  r_sclk_d & ~w_sclk_s;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  spi_state_t r_state;
  spi_state_t w_state_nxt;

  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_cs_fall) w_state_nxt = RECV;
      RECV: if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Out_rx_busy = 1'b0;
    if (r_state == RECV) Out_rx_busy = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [2:0]            r_bit_cnt;
  logic [SPI_DATA_W-1:0] r_shift;
  logic [SPI_DATA_W-1:0] r_data;
  logic                  r_valid;
  logic                  w_take_bit;
  logic                  w_byte_done;
  logic [SPI_DATA_W-1:0] w_shift_nxt;

  // Bits are only taken in RECV; a CS_n fall (only possible in IDLE) therefore
  // masks any SCLK edge detected in the same cycle.
  assign w_take_bit  = (r_state == RECV) & w_sclk_fall;
  assign w_byte_done = w_take_bit & (r_bit_cnt == 3'd7);
  assign w_shift_nxt = {r_shift[SPI_DATA_W-2:0], w_mosi_s};

  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE && w_cs_fall) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= '0;
      end else if (w_take_bit) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= r_bit_cnt + 3'd1;  // wraps 7 -> 0 at the byte boundary
        if (w_byte_done) begin
          r_data  <= w_shift_nxt;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign Out_rx_data  = r_data;
  assign Out_rx_valid = r_valid;

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
  // A frame end is an abort when bits have been collected for a byte that
  // does not complete in this same cycle.
  logic r_err;
  logic w_abort;

  assign w_abort = (r_state == RECV) & w_cs_rise & ~w_byte_done &
                   ((r_bit_cnt != 3'd0) | w_take_bit);

  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
    end
  end

  assign Out_rx_err = r_err;
`endif

endmodule

// File: tb/tb_spi_slave_rx_mode1.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx_mode1
//   Drives SPI mode-1 frames at the maximum accepted SCLK rate and checks the
//   received bytes through an expected-byte queue. Define
//   SPI_SLAVE_RX_FRAME_ERR_EN to also check the abort pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_rx_mode1;

  localparam int REF_CLK     = 50_000_000;
  localparam int SPI_SCLK    = 50_000;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = REF_CLK / SPI_SCLK / 2;  // In_clk cycles per SCLK half period

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       Out_rx_busy;
  logic       Out_rx_valid;
  logic [7:0] Out_rx_data;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
  logic       Out_rx_err;
`endif

  always #10 clk = ~clk;

  spi_slave_rx_mode1 #(
    .REF_CLK    (REF_CLK),
    .SPI_SCLK   (SPI_SCLK),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .In_clk      (clk),
    .In_rst      (rst),
    .In_spi_cs_n (cs_n),
    .In_spi_sclk (sclk),
    .In_spi_mosi (mosi),
    .Out_rx_busy (Out_rx_busy),
    .Out_rx_valid(Out_rx_valid),
    .Out_rx_data (Out_rx_data)
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    ,
    .Out_rx_err  (Out_rx_err)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         pulse_cnt = 0;
  int         err_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (Out_rx_valid) begin
      pulse_cnt++;
      n_cmp++;
      if (prev_valid) begin
        n_mis++;
        $display("FAIL valid_width: Out_rx_valid high for more than one cycle at %0t", $time);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_pulse: got data %02h, expected no pulse", Out_rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (Out_rx_data !== e) begin
          n_mis++;
          $display("FAIL rx_data: got %02h, expected %02h", Out_rx_data, e);
        end
        last_data = e;
      end
    end
    prev_valid = Out_rx_valid;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    if (Out_rx_err) err_cnt++;
`endif
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode 1: master changes MOSI on the rising edge, slave samples on the fall.
  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      wait_clks(HALF);
      sclk = 1'b1;
      mosi = b[7-i];
      wait_clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    wait_clks(4);
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    wait_clks(5);
    n_cmp++;
    if (Out_rx_busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b, expected 0", Out_rx_busy); end
    n_cmp++;
    if (Out_rx_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b, expected 0", Out_rx_valid); end
    n_cmp++;
    if (Out_rx_data !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %02h, expected 00", Out_rx_data); end
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    n_cmp++;
    if (Out_rx_err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b, expected 0", Out_rx_err); end
`endif
    rst = 1'b0;
    wait_clks(5);
  endtask

  // One byte 8'h12, busy tracking and valid latency after the 8th SCLK fall.
  task automatic test_single_byte();
    int p0;
    int lat;
    p0 = pulse_cnt;
    exp_q.push_back(8'h12);
    cs_low();
    wait_clks(6);
    n_cmp++;
    if (Out_rx_busy !== 1'b1) begin n_mis++; $display("FAIL busy_in_frame: got %b, expected 1", Out_rx_busy); end
    spi_bits(8'h12, 8);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (Out_rx_valid && lat == 0) lat = k;
    end
    n_cmp++;
    if (lat != SYNC_STAGES + 1) begin
      n_mis++;
      $display("FAIL valid_latency: got %0d cycles, expected %0d", lat, SYNC_STAGES + 1);
    end
    cs_high();
    n_cmp++;
    if (Out_rx_busy !== 1'b0) begin n_mis++; $display("FAIL busy_after_frame: got %b, expected 0", Out_rx_busy); end
    n_cmp++;
    if (pulse_cnt - p0 != 1) begin n_mis++; $display("FAIL single_pulses: got %0d, expected 1", pulse_cnt - p0); end
    n_cmp++;
    if (Out_rx_data !== 8'h12) begin n_mis++; $display("FAIL single_hold: got %02h, expected 12", Out_rx_data); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    cs_low();
    spi_bits(8'h55, 8);
    spi_bits(8'hA3, 8);
    cs_high();
    n_cmp++;
    if (pulse_cnt - p0 != 2) begin n_mis++; $display("FAIL b2b_pulses: got %0d, expected 2", pulse_cnt - p0); end
    n_cmp++;
    if (Out_rx_data !== 8'hA3) begin n_mis++; $display("FAIL b2b_hold: got %02h, expected a3", Out_rx_data); end
  endtask

  task automatic test_abort();
    int p0;
    int e0;
    p0 = pulse_cnt;
    e0 = err_cnt;
    cs_low();
    spi_bits(8'hFF, 5);
    cs_high();
    wait_clks(4);
    n_cmp++;
    if (pulse_cnt != p0) begin n_mis++; $display("FAIL abort_pulses: got %0d, expected 0", pulse_cnt - p0); end
    n_cmp++;
    if (Out_rx_data !== last_data) begin n_mis++; $display("FAIL abort_hold: got %02h, expected %02h", Out_rx_data, last_data); end
    n_cmp++;
    if (Out_rx_busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b, expected 0", Out_rx_busy); end
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    n_cmp++;
    if (err_cnt - e0 != 1) begin n_mis++; $display("FAIL abort_err: got %0d pulses, expected 1", err_cnt - e0); end
`endif
  endtask

  task automatic test_idle_activity();
    int p0;
    p0 = pulse_cnt;
    // 16 SCLK toggles with random MOSI while CS_n stays high.
    for (int i = 0; i < 8; i++) begin
      wait_clks(HALF);
      sclk = 1'b1;
      mosi = 1'($urandom_range(0, 1));
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(8);
    n_cmp++;
    if (pulse_cnt != p0) begin n_mis++; $display("FAIL idle_pulses: got %0d, expected 0", pulse_cnt - p0); end
    n_cmp++;
    if (Out_rx_busy !== 1'b0) begin n_mis++; $display("FAIL idle_busy: got %b, expected 0", Out_rx_busy); end
    exp_q.push_back(8'h3C);
    cs_low();
    spi_bits(8'h3C, 8);
    cs_high();
    n_cmp++;
    if (pulse_cnt - p0 != 1) begin n_mis++; $display("FAIL idle_frame_pulses: got %0d, expected 1", pulse_cnt - p0); end
    n_cmp++;
    if (Out_rx_data !== 8'h3C) begin n_mis++; $display("FAIL idle_frame_data: got %02h, expected 3c", Out_rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    p0 = pulse_cnt;
    cs_low();
    spi_bits(8'hC7, 4);
    wait_clks(HALF / 2);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (Out_rx_busy !== 1'b0) begin n_mis++; $display("FAIL midrst_busy: got %b, expected 0", Out_rx_busy); end
    n_cmp++;
    if (Out_rx_data !== 8'h00) begin n_mis++; $display("FAIL midrst_data: got %02h, expected 00", Out_rx_data); end
    last_data = 8'h00;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(8);
    n_cmp++;
    if (pulse_cnt != p0) begin n_mis++; $display("FAIL midrst_pulses: got %0d, expected 0", pulse_cnt - p0); end
    exp_q.push_back(8'h81);
    cs_low();
    spi_bits(8'h81, 8);
    cs_high();
    n_cmp++;
    if (pulse_cnt - p0 != 1) begin n_mis++; $display("FAIL after_rst_pulses: got %0d, expected 1", pulse_cnt - p0); end
    n_cmp++;
    if (Out_rx_data !== 8'h81) begin n_mis++; $display("FAIL after_rst_data: got %02h, expected 81", Out_rx_data); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_idle_activity();
    test_reset_mid_frame();
    wait_clks(10);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL queue_drain: %0d bytes never received, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
